// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: shared types and constants for the UART register bridge.
// Holds the FSM state encoding, the command-byte layout and the default
// response bytes used by uart_reg_bridge.
package uart_bridge_pkg;

    // Command engine states, in the order a transaction walks through them.
    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        BUS_WR,
        BUS_RD,
        WAIT_RD,
        SEND
    } state_t;

    // Bit 7 of the command byte selects write (1) or read (0); bits 6:0 are the address.
    localparam int CMD_WR_BIT = 7;

    localparam logic [7:0] DEFAULT_ACK_BYTE = 8'h06;
    localparam logic [7:0] DEFAULT_ERR_BYTE = 8'hEE;

    function automatic logic is_write_cmd(input logic [7:0] cmd);
        return cmd[CMD_WR_BIT];
    endfunction

endpackage

// File: rtl/uart_reg_bridge_if.sv
// uart_reg_bridge_if: byte-stream and register-bus signals of the bridge.
// The master modport is the bridge itself; the slave modport is the
// environment (UART FIFOs on one side, register file on the other).
interface uart_reg_bridge_if;

    // UART receive side
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rx_rd_stb;

    // UART transmit side
    logic       tx_full;
    logic [7:0] tx_data;
    logic       tx_wr_stb;

    // Register bus
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       reg_rvalid;

    modport master (
        input  rx_empty, rx_data, tx_full, reg_rdata, reg_rvalid,
        output rx_rd_stb, tx_data, tx_wr_stb, reg_addr, reg_wdata, reg_wr, reg_rd
    );

    modport slave (
        output rx_empty, rx_data, tx_full, reg_rdata, reg_rvalid,
        input  rx_rd_stb, tx_data, tx_wr_stb, reg_addr, reg_wdata, reg_wr, reg_rd
    );

endinterface

// File: rtl/uart_bridge_timeout.sv
// uart_bridge_timeout: loadable down-counter used to bound the wait for read
// data. Loading sets it to CYCLES-1; it then counts down once per cycle and
// holds at zero, where done is raised. Only instantiated when
// UART_REG_BRIDGE_TIMEOUT_EN is defined. CYCLES must be at least 2.
module uart_bridge_timeout #(
    parameter int unsigned CYCLES = 256
) (
    input  logic clk_main,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int W = $clog2(CYCLES);

    logic [W-1:0] count;

    // Reload on request, otherwise count down and saturate at zero.
    always_ff @(posedge clk_main) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= W'(CYCLES - 1);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: UART-to-register-bus command engine.
// Pops command bytes from the UART receive FIFO, performs one register read
// or write per command and pushes a single response byte (ACK for writes,
// read data for reads). Define UART_REG_BRIDGE_TIMEOUT_EN to bound the wait
// for read data; on expiry ERR_BYTE is returned instead.
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter logic [7:0] ACK_BYTE = DEFAULT_ACK_BYTE
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    ,
    parameter logic [7:0]  ERR_BYTE       = DEFAULT_ERR_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
    input  logic              clk_main,
    input  logic              rst,
    uart_reg_bridge_if.master bus,
    output logic              busy
);

    state_t state;
    logic   pop;

    // Pop only while waiting for a command or write-data byte; rx_data is
    // captured on the same edge the strobe is high.
    assign pop           = ((state == IDLE) || (state == GET_DATA)) && !bus.rx_empty;
    assign bus.rx_rd_stb = pop;
    assign busy          = (state != IDLE);

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    logic rd_timeout;

    // Loaded during BUS_RD so it expires on the TIMEOUT_CYCLES-th WAIT_RD cycle.
    uart_bridge_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_main (clk_main),
        .rst      (rst),
        .load     (state == BUS_RD),
        .done     (rd_timeout)
    );
`endif

    // Command FSM; every strobe is registered and high during the cycle the
    // FSM sits in the state that owns it.
    // NOTE: the reset here is synchronous -- it is just the highest-priority
    // branch of the clocked block, so it needs no separate sensitivity.
    always_ff @(posedge clk_main) begin
        if (rst) begin
            state         <= IDLE;
            bus.tx_data   <= '0;
            bus.tx_wr_stb <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            bus.reg_wr    <= 1'b0;
            bus.reg_rd    <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make the bus strobes one-cycle pulses;
            // a later assignment in the case below overrides them.
            bus.reg_wr <= 1'b0;
            bus.reg_rd <= 1'b0;

            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.reg_addr <= bus.rx_data[6:0];
                        if (is_write_cmd(bus.rx_data)) begin
                            state <= GET_DATA;
                        end else begin
                            bus.reg_rd <= 1'b1;
                            state      <= BUS_RD;
                        end
                    end
                end

                GET_DATA: begin
                    if (pop) begin
                        bus.reg_wdata <= bus.rx_data;
                        bus.reg_wr    <= 1'b1;
                        state         <= BUS_WR;
                    end
                end

                BUS_WR: begin
                    bus.tx_data   <= ACK_BYTE;
                    bus.tx_wr_stb <= !bus.tx_full;
                    state         <= SEND;
                end

                BUS_RD: begin
                    state <= WAIT_RD;
                end

                WAIT_RD: begin
                    if (bus.reg_rvalid) begin
                        bus.tx_data   <= bus.reg_rdata;
                        bus.tx_wr_stb <= !bus.tx_full;
                        state         <= SEND;
                    end
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
                    else if (rd_timeout) begin
                        bus.tx_data   <= ERR_BYTE;
                        bus.tx_wr_stb <= !bus.tx_full;
                        state         <= SEND;
                    end
`endif
                end

                SEND: begin
                    // A cycle with the strobe high is the push; leave right after it.
                    if (bus.tx_wr_stb) begin
                        bus.tx_wr_stb <= 1'b0;
                        state         <= IDLE;
                    end else if (!bus.tx_full) begin
                        bus.tx_wr_stb <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge: directed self-checking bench for uart_reg_bridge.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. A monitor records every strobe with its cycle number.
module tb_uart_reg_bridge;

    logic clk;
    logic rst;
    logic busy;

    uart_reg_bridge_if bus_if ();

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    uart_reg_bridge #(.TIMEOUT_CYCLES(16)) u_dut (
        .clk_main (clk),
        .rst      (rst),
        .bus      (bus_if),
        .busy     (busy)
    );
`else
    uart_reg_bridge u_dut (
        .clk_main (clk),
        .rst      (rst),
        .bus      (bus_if),
        .busy     (busy)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Strobe monitor
    int         pop_cnt = 0;
    int         wr_cnt  = 0;
    int         rd_cnt  = 0;
    int         tx_cnt  = 0;
    int         wr_cyc  = 0;
    int         rd_cyc  = 0;
    int         tx_cyc  = 0;
    logic [6:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [6:0] rd_addr = '0;
    logic [7:0] tx_byte = '0;

    always @(negedge clk) begin
        if (bus_if.rx_rd_stb === 1'b1) pop_cnt++;
        if (bus_if.reg_wr === 1'b1) begin
            wr_cnt++;
            wr_addr = bus_if.reg_addr;
            wr_data = bus_if.reg_wdata;
            wr_cyc  = cyc;
        end
        if (bus_if.reg_rd === 1'b1) begin
            rd_cnt++;
            rd_addr = bus_if.reg_addr;
            rd_cyc  = cyc;
        end
        if (bus_if.tx_wr_stb === 1'b1) begin
            tx_cnt++;
            tx_byte = bus_if.tx_data;
            tx_cyc  = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and wait (bounded) for the bridge to pop it.
    task automatic push_byte(input logic [7:0] b, output int pop_at);
        bit got;
        got    = 1'b0;
        pop_at = -1;
        bus_if.rx_data  = b;
        bus_if.rx_empty = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus_if.rx_rd_stb === 1'b1) begin
                got    = 1'b1;
                pop_at = cyc;
            end
            tick();
        end
        bus_if.rx_empty = 1'b1;
        bus_if.rx_data  = 8'h00;
        check("pop_seen", 32'(got), 32'd1);
    endtask

    // One-cycle reg_rvalid pulse starting now.
    task automatic give_rvalid(input logic [7:0] d);
        bus_if.reg_rvalid = 1'b1;
        bus_if.reg_rdata  = d;
        tick();
        bus_if.reg_rvalid = 1'b0;
        bus_if.reg_rdata  = 8'h00;
    endtask

    // Wait (bounded) for reg_rd to be seen on a falling edge.
    task automatic wait_reg_rd(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus_if.reg_rd === 1'b1) seen = 1'b1;
        end
    endtask

    int  p0, p1, rv_cyc, fall_cyc, pops_before, tx_before;
    bit  seen;

    initial begin
        rst               = 1'b1;
        bus_if.rx_empty   = 1'b1;
        bus_if.rx_data    = 8'h00;
        bus_if.tx_full    = 1'b0;
        bus_if.reg_rdata  = 8'h00;
        bus_if.reg_rvalid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_tx_data",   32'(bus_if.tx_data),   32'h00);
        check("rst_tx_wr_stb", 32'(bus_if.tx_wr_stb), 32'd0);
        check("rst_reg_addr",  32'(bus_if.reg_addr),  32'h00);
        check("rst_reg_wdata", 32'(bus_if.reg_wdata), 32'h00);
        check("rst_reg_wr",    32'(bus_if.reg_wr),    32'd0);
        check("rst_reg_rd",    32'(bus_if.reg_rd),    32'd0);
        check("rst_busy",      32'(busy),             32'd0);
        check("rst_no_pop",    32'(bus_if.rx_rd_stb), 32'd0);
        tick();

        // 1. Write 0x85, 0x3C
        push_byte(8'h85, p0);
        push_byte(8'h3C, p1);
        check("w1_data_pop_next_cycle", 32'(p1 - p0), 32'd1);
        repeat (6) tick();
        check("w1_wr_cnt",   32'(wr_cnt),  32'd1);
        check("w1_addr",     32'(wr_addr), 32'h05);
        check("w1_wdata",    32'(wr_data), 32'h3C);
        check("w1_wr_lat",   32'(wr_cyc - p0), 32'd2);
        check("w1_tx_cnt",   32'(tx_cnt),  32'd1);
        check("w1_tx_byte",  32'(tx_byte), 32'h06);
        check("w1_tx_lat",   32'(tx_cyc - wr_cyc), 32'd1);
        check("w1_rd_cnt",   32'(rd_cnt),  32'd0);
        check("w1_busy_low", 32'(busy),    32'd0);

        // 2. Read 0x12, rvalid 3 cycles after reg_rd
        push_byte(8'h12, p0);
        wait_reg_rd(seen);
        check("r2_reg_rd_seen", 32'(seen), 32'd1);
        repeat (3) tick();
        rv_cyc = cyc;
        give_rvalid(8'hA7);
        repeat (4) tick();
        check("r2_rd_cnt",  32'(rd_cnt),  32'd1);
        check("r2_rd_addr", 32'(rd_addr), 32'h12);
        check("r2_rd_lat",  32'(rd_cyc - p0), 32'd1);
        check("r2_tx_cnt",  32'(tx_cnt),  32'd2);
        check("r2_tx_byte", 32'(tx_byte), 32'hA7);
        check("r2_tx_lat",  32'(tx_cyc - rv_cyc), 32'd1);
        check("r2_wr_cnt",  32'(wr_cnt),  32'd1);
        check("r2_busy",    32'(busy),    32'd0);

        // 3. Back-pressure: tx_full high for 10 cycles in SEND
        bus_if.tx_full = 1'b1;
        push_byte(8'hA0, p0);
        push_byte(8'h11, p1);
        tick();
        repeat (10) tick();
        check("bp_no_push",   32'(tx_cnt), 32'd2);
        check("bp_busy_held", 32'(busy),   32'd1);
        bus_if.tx_full = 1'b0;
        fall_cyc = cyc;
        repeat (5) tick();
        check("bp_tx_cnt",  32'(tx_cnt),  32'd3);
        check("bp_tx_byte", 32'(tx_byte), 32'h06);
        check("bp_tx_when", 32'(tx_cyc - fall_cyc), 32'd1);
        check("bp_addr",    32'(wr_addr), 32'h20);
        check("bp_wdata",   32'(wr_data), 32'h11);

        // 4. 50-cycle gap between command and data bytes
        push_byte(8'h90, p0);
        pops_before = pop_cnt;
        repeat (50) tick();
        check("gap_no_pop",    32'(pop_cnt), 32'(pops_before));
        check("gap_busy",      32'(busy),    32'd1);
        check("gap_no_wr",     32'(wr_cnt),  32'd2);
        push_byte(8'h55, p1);
        repeat (5) tick();
        check("gap_wr_cnt",  32'(wr_cnt),  32'd3);
        check("gap_addr",    32'(wr_addr), 32'h10);
        check("gap_wdata",   32'(wr_data), 32'h55);
        check("gap_tx_cnt",  32'(tx_cnt),  32'd4);
        check("gap_tx_byte", 32'(tx_byte), 32'h06);

        // 5. Reset while waiting for read data
        push_byte(8'h33, p0);
        tick();
        tick();
        check("rst5_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst5_busy",      32'(busy),             32'd0);
        check("rst5_tx_data",   32'(bus_if.tx_data),   32'h00);
        check("rst5_tx_wr_stb", 32'(bus_if.tx_wr_stb), 32'd0);
        check("rst5_reg_addr",  32'(bus_if.reg_addr),  32'h00);
        check("rst5_reg_wdata", 32'(bus_if.reg_wdata), 32'h00);
        check("rst5_reg_rd",    32'(bus_if.reg_rd),    32'd0);
        tick();
        tx_before = tx_cnt;
        give_rvalid(8'h5A);
        repeat (5) tick();
        check("rst5_late_rvalid", 32'(tx_cnt), 32'(tx_before));
        check("rst5_idle",        32'(busy),   32'd0);

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
        // 6. Read timeout (TIMEOUT_CYCLES=16): ERR 16 cycles after WAIT_RD entry
        tx_before = tx_cnt;
        push_byte(8'h01, p0);
        repeat (25) tick();
        check("to_tx_cnt",  32'(tx_cnt),  32'(tx_before + 1));
        check("to_tx_byte", 32'(tx_byte), 32'hEE);
        check("to_tx_when", 32'(tx_cyc - p0), 32'd18);
        give_rvalid(8'h77);
        repeat (5) tick();
        check("to_late_ignored", 32'(tx_cnt), 32'(tx_before + 1));
        push_byte(8'h02, p0);
        wait_reg_rd(seen);
        check("to_next_rd_seen", 32'(seen), 32'd1);
        tick();
        give_rvalid(8'h3C);
        repeat (4) tick();
        check("to_next_tx_cnt",  32'(tx_cnt),  32'(tx_before + 2));
        check("to_next_tx_byte", 32'(tx_byte), 32'h3C);
        check("to_next_rd_addr", 32'(rd_addr), 32'h02);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
